// File: rtl/pwm_period_meter.sv
// Measures high time, low time and period of a slow signal (divider/PWM output)
// in system-clock cycles, and flags a lost signal when a phase overruns the counters.
module pwm_period_meter #(
    parameter int CNT_SIZE = 8
) (
    input  logic                ClkIn,
    input  logic                Reset,
    input  logic                SigIn,
    output logic [CNT_SIZE-1:0] HighTime,
    output logic [CNT_SIZE-1:0] LowTime,
    output logic [CNT_SIZE:0]   Period,
    output logic                MeasValid,
    output logic                NoSignal
);

    typedef enum logic [1:0] {ARM, IDLE, MEAS_HIGH, MEAS_LOW} state_t;

    localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;
    localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);

    state_t              state;
    logic                s1, s2, s3;
    logic [1:0]          pr_cnt;
    logic [CNT_SIZE-1:0] high_cnt;
    logic [CNT_SIZE-1:0] low_cnt;
    logic                rise;
    logic                fall;

    // True when one more increment would leave the measurable range.
    function automatic logic would_overflow(input logic [CNT_SIZE-1:0] cnt);
        return cnt == CNT_MAX;
    endfunction

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge ClkIn or posedge Reset) begin
        if (Reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            state     <= ARM;
            pr_cnt    <= 2'd0;
            high_cnt  <= '0;
            low_cnt   <= '0;
            HighTime  <= '0;
            LowTime   <= '0;
            Period    <= '0;
            MeasValid <= 1'b0;
            NoSignal  <= 1'b0;
        end else begin
            s1        <= SigIn;
            s2        <= s1;
            s3        <= s2;
            MeasValid <= 1'b0;
            case (state)
                // Wait until the synchronizer holds real samples and the input is low,
                // so the reset-induced 0->1 step on a high input is never taken as a rise.
                ARM: begin
                    if (pr_cnt != 2'd3) begin
                        pr_cnt <= pr_cnt + 2'd1;
                    end else if (!s3) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (rise) begin
                        high_cnt <= CNT_ONE;
                        state    <= MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        low_cnt <= CNT_ONE;
                        state   <= MEAS_LOW;
                    end else if (would_overflow(high_cnt)) begin
                        NoSignal <= 1'b1;
                        high_cnt <= '0;
                        low_cnt  <= '0;
                        state    <= IDLE;
                    end else begin
                        high_cnt <= high_cnt + CNT_ONE;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        HighTime  <= high_cnt;
                        LowTime   <= low_cnt;
                        Period    <= (CNT_SIZE+1)'(high_cnt) + (CNT_SIZE+1)'(low_cnt);
                        MeasValid <= 1'b1;
                        NoSignal  <= 1'b0;
                        high_cnt  <= CNT_ONE;
                        state     <= MEAS_HIGH;
                    end else if (would_overflow(low_cnt)) begin
                        NoSignal <= 1'b1;
                        high_cnt <= '0;
                        low_cnt  <= '0;
                        state    <= IDLE;
                    end else begin
                        low_cnt <= low_cnt + CNT_ONE;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_period_meter.sv
// Bench for pwm_period_meter: two instances (CNT_SIZE 8 and 6) share stimulus; results are
// compared against a run-length model of the sampled input.
module tb_pwm_period_meter;

    typedef struct {
        int ht;
        int lt;
        int per;
        int mv;
        int ns;
    } obs_t;

    logic       ClkIn = 1'b0;
    logic       Reset = 1'b1;
    logic       SigIn = 1'b0;
    logic [7:0] high8, low8;
    logic [8:0] per8;
    logic       mv8, ns8;
    logic [5:0] high6, low6;
    logic [6:0] per6;
    logic       mv6, ns6;

    int   checks = 0;
    int   errors = 0;
    bit   rec = 1'b0;
    int   x_q[$];
    obs_t o8[$];
    obs_t o6[$];

    pwm_period_meter #(.CNT_SIZE(8)) dut8 (
        .ClkIn(ClkIn), .Reset(Reset), .SigIn(SigIn),
        .HighTime(high8), .LowTime(low8), .Period(per8),
        .MeasValid(mv8), .NoSignal(ns8)
    );

    pwm_period_meter #(.CNT_SIZE(6)) dut6 (
        .ClkIn(ClkIn), .Reset(Reset), .SigIn(SigIn),
        .HighTime(high6), .LowTime(low6), .Period(per6),
        .MeasValid(mv6), .NoSignal(ns6)
    );

    always #5 ClkIn = ~ClkIn;

    always @(posedge ClkIn) if (rec) x_q.push_back(int'(SigIn));

    always @(negedge ClkIn) begin
        if (rec && o8.size() < x_q.size()) begin
            o8.push_back('{int'(high8), int'(low8), int'(per8), int'(mv8), int'(ns8)});
            o6.push_back('{int'(high6), int'(low6), int'(per6), int'(mv6), int'(ns6)});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_segment(input logic init);
        @(negedge ClkIn);
        rec   = 1'b0;
        Reset = 1'b1;
        SigIn = init;
        x_q.delete();
        o8.delete();
        o6.delete();
        repeat (3) @(negedge ClkIn);
        Reset = 1'b0;
        rec   = 1'b1;
    endtask

    task automatic drive(input logic level, input int len);
        repeat (len) begin
            SigIn = level;
            @(negedge ClkIn);
        end
    endtask

    task automatic end_segment;
        #1 rec = 1'b0;
    endtask

    // Expected per-edge outputs from the run lengths of the sampled input. Sample k (1-based)
    // is SigIn at the k-th edge after reset release; a rise between samples m-1 and m takes
    // effect on edge m+2. Rises are honoured once the input has been seen low after arming.
    task automatic build_expect(input int w, output obs_t e[$], output int n_ev);
        int   n, mx, j, act;
        int   rs[$], rl[$], rv[$];
        int   ev_e[$], ev_h[$], ev_l[$], sat_e[$];
        obs_t cur;
        n  = x_q.size();
        mx = (1 << w) - 1;
        j  = 0;
        e.delete();
        for (int k = 0; k < n; k++) begin
            if (k == 0 || x_q[k] != x_q[k-1]) begin
                rs.push_back(k + 1);
                rl.push_back(1);
                rv.push_back(x_q[k]);
            end else begin
                rl[rl.size()-1] = rl[rl.size()-1] + 1;
            end
            if (j == 0 && x_q[k] == 0) j = k + 1;
        end
        act = -1;
        if (j != 0) begin
            for (int r = 0; r < rs.size(); r++) begin
                if (rv[r] == 1 && rs[r] >= j + 2) begin
                    if (act >= 0) begin
                        ev_e.push_back(rs[r] + 2);
                        ev_h.push_back(rl[act]);
                        ev_l.push_back(rl[act+1]);
                    end
                    act = -1;
                    if (rl[r] > mx) begin
                        sat_e.push_back(rs[r] + mx + 2);
                    end else if (r + 1 < rs.size()) begin
                        if (rl[r+1] > mx) sat_e.push_back(rs[r+1] + mx + 2);
                        else act = r;
                    end
                end
            end
        end
        cur = '{0, 0, 0, 0, 0};
        for (int ed = 1; ed <= n; ed++) begin
            cur.mv = 0;
            foreach (ev_e[i]) begin
                if (ev_e[i] == ed) begin
                    cur.ht  = ev_h[i];
                    cur.lt  = ev_l[i];
                    cur.per = ev_h[i] + ev_l[i];
                    cur.mv  = 1;
                    cur.ns  = 0;
                end
            end
            foreach (sat_e[i]) if (sat_e[i] == ed) cur.ns = 1;
            e.push_back(cur);
        end
        n_ev = 0;
        foreach (ev_e[i]) if (ev_e[i] <= n) n_ev++;
    endtask

    task automatic compare_trace(input string tag, input int w, input obs_t o[$]);
        obs_t e[$];
        int   n_ev, bad_data, bad_mv, bad_ns, seen_mv;
        build_expect(w, e, n_ev);
        check_val({tag, " trace length"}, o.size(), e.size());
        bad_data = 0;
        bad_mv   = 0;
        bad_ns   = 0;
        seen_mv  = 0;
        for (int i = 0; i < e.size() && i < o.size(); i++) begin
            if (o[i].ht != e[i].ht || o[i].lt != e[i].lt || o[i].per != e[i].per) bad_data++;
            if (o[i].mv != e[i].mv) bad_mv++;
            if (o[i].ns != e[i].ns) bad_ns++;
            seen_mv += o[i].mv;
        end
        check_val({tag, " meas count"}, seen_mv, n_ev);
        check_val({tag, " data cycles wrong"}, bad_data, 0);
        check_val({tag, " valid cycles wrong"}, bad_mv, 0);
        check_val({tag, " nosignal cycles wrong"}, bad_ns, 0);
    endtask

    task automatic check_meas(input string tag, input obs_t o[$], input bit first,
                              input int h, input int l);
        int idx = -1;
        foreach (o[i]) if (o[i].mv == 1 && (idx < 0 || !first)) idx = i;
        check_val({tag, " found"}, int'(idx >= 0), 1);
        if (idx >= 0) begin
            check_val({tag, " high"}, o[idx].ht, h);
            check_val({tag, " low"}, o[idx].lt, l);
            check_val({tag, " period"}, o[idx].per, h + l);
        end
    endtask

    initial begin
        int idx;

        // reset state
        repeat (2) @(negedge ClkIn);
        check_val("rst high8", int'(high8), 0);
        check_val("rst low8", int'(low8), 0);
        check_val("rst per8", int'(per8), 0);
        check_val("rst mv8", int'(mv8), 0);
        check_val("rst ns8", int'(ns8), 0);

        // 1: 10 high / 21 low
        start_segment(1'b0);
        drive(1'b0, 5);
        repeat (4) begin drive(1'b1, 10); drive(1'b0, 21); end
        drive(1'b1, 3);
        end_segment();
        compare_trace("t1 w8", 8, o8);
        compare_trace("t1 w6", 6, o6);
        check_meas("t1 w8 first", o8, 1'b1, 10, 21);
        check_meas("t1 w8 last", o8, 1'b0, 10, 21);
        check_val("t1 w8 ns end", o8[o8.size()-1].ns, 0);

        // 2: toggling every cycle
        start_segment(1'b0);
        drive(1'b0, 6);
        repeat (20) begin drive(1'b1, 1); drive(1'b0, 1); end
        end_segment();
        compare_trace("t2 w8", 8, o8);
        compare_trace("t2 w6", 6, o6);
        check_meas("t2 w8 first", o8, 1'b1, 1, 1);
        check_meas("t2 w6 last", o6, 1'b0, 1, 1);

        // 3: signal lost low for 80 cycles, then 5/7
        start_segment(1'b0);
        drive(1'b0, 5);
        drive(1'b1, 10); drive(1'b0, 21);
        drive(1'b1, 10); drive(1'b0, 80);
        repeat (3) begin drive(1'b1, 5); drive(1'b0, 7); end
        drive(1'b1, 2);
        end_segment();
        compare_trace("t3 w8", 8, o8);
        compare_trace("t3 w6", 6, o6);
        idx = -1;
        foreach (o6[i]) if (o6[i].ns == 1 && idx < 0) idx = i;
        check_val("t3 w6 nosignal seen", int'(idx >= 0), 1);
        if (idx >= 0) begin
            check_val("t3 w6 held high", o6[idx].ht, 10);
            check_val("t3 w6 held low", o6[idx].lt, 21);
            check_val("t3 w6 held period", o6[idx].per, 31);
        end
        check_meas("t3 w6 last", o6, 1'b0, 5, 7);
        check_val("t3 w6 ns end", o6[o6.size()-1].ns, 0);

        // 4: high through reset release
        start_segment(1'b1);
        drive(1'b1, 4);
        repeat (3) begin drive(1'b0, 8); drive(1'b1, 8); end
        drive(1'b0, 2);
        end_segment();
        compare_trace("t4 w8", 8, o8);
        compare_trace("t4 w6", 6, o6);
        check_meas("t4 w8 first", o8, 1'b1, 8, 8);

        // 5: asynchronous reset in a low phase, then restart
        start_segment(1'b0);
        drive(1'b0, 5);
        repeat (2) begin drive(1'b1, 10); drive(1'b0, 21); end
        drive(1'b1, 10);
        drive(1'b0, 8);
        end_segment();
        compare_trace("t5 w8", 8, o8);
        @(posedge ClkIn);
        #2;
        check_val("t5 pre high8", int'(high8), 10);
        Reset = 1'b1;
        #1;
        check_val("t5 async high8", int'(high8), 0);
        check_val("t5 async low8", int'(low8), 0);
        check_val("t5 async per8", int'(per8), 0);
        check_val("t5 async mv8", int'(mv8), 0);
        check_val("t5 async ns8", int'(ns8), 0);
        check_val("t5 async high6", int'(high6), 0);
        check_val("t5 async per6", int'(per6), 0);
        start_segment(1'b0);
        drive(1'b0, 5);
        repeat (3) begin drive(1'b1, 10); drive(1'b0, 21); end
        drive(1'b1, 2);
        end_segment();
        compare_trace("t5b w8", 8, o8);
        check_meas("t5b w8 first", o8, 1'b1, 10, 21);

        // 6: full-range phases, then one cycle too long
        start_segment(1'b0);
        drive(1'b0, 5);
        repeat (2) begin drive(1'b1, 255); drive(1'b0, 255); end
        drive(1'b1, 256);
        drive(1'b0, 10);
        end_segment();
        compare_trace("t6 w8", 8, o8);
        compare_trace("t6 w6", 6, o6);
        check_meas("t6 w8 first", o8, 1'b1, 255, 255);
        check_meas("t6 w8 last", o8, 1'b0, 255, 255);
        check_val("t6 w8 ns end", o8[o8.size()-1].ns, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
